// File: rtl/frame_sanitizer.sv
`default_nettype none
// frame_sanitizer: enforces header/data/footer framing on the mixer output stream and keeps
// saturating error counters for run monitoring. rev 1.0
module frame_sanitizer #(
   parameter int DATA_WIDTH    = 64,
   parameter int MAX_FRAME_LEN = 4095,
   parameter int CNT_WIDTH     = 16
) (
   input  logic                  CLK,
   input  logic                  RESETN,
   input  logic [DATA_WIDTH-1:0] DIN,
   input  logic                  iVALID,
   output logic                  oREADY,
   output logic [DATA_WIDTH-1:0] DOUT,
   output logic                  oVALID,
   input  logic                  iREADY,
   output logic [CNT_WIDTH-1:0]  HDR_LOST_CNT,
   output logic [CNT_WIDTH-1:0]  FTR_LOST_CNT,
   output logic [CNT_WIDTH-1:0]  LEN_ERR_CNT
);

   localparam logic [DATA_WIDTH-1:0] SYNTH_FTR = DATA_WIDTH'(64'h8000_8000_0000_5555);
   localparam logic [11:0]           MAX_LEN   = 12'(MAX_FRAME_LEN);
   localparam logic [CNT_WIDTH-1:0]  CNT_MAX   = '1;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      FRAME   = 2'd1,
      CLOSE   = 2'd2,
      DISCARD = 2'd3
   } state_t;

   state_t                state, state_nx;
   logic [11:0]           frame_len, frame_len_nx;
   logic [11:0]           word_cnt, word_cnt_nx;
   logic [DATA_WIDTH-1:0] dout_nx;
   logic                  ovalid_nx;
   logic                  started;
   logic                  is_hdr, is_ftr;
   logic                  out_free, hdr_break, accept;
   logic                  hdr_lost_inc, ftr_lost_inc, len_err_inc;

   assign is_hdr    = (DIN[DATA_WIDTH-1 -: 16] == 16'hAAAA);
   assign is_ftr    = (DIN[15:0] == 16'h5555) && !is_hdr;
   assign out_free  = !oVALID || iREADY;
   // A header arriving inside a frame is refused so upstream re-presents it after the synthetic footer.
   assign hdr_break = (state == FRAME) && iVALID && is_hdr;
   assign oREADY    = started && out_free && (state != CLOSE) && !hdr_break;
   assign accept    = iVALID && oREADY;

   always_comb begin
      state_nx     = state;
      frame_len_nx = frame_len;
      word_cnt_nx  = word_cnt;
      dout_nx      = DOUT;
      ovalid_nx    = oVALID && !iREADY;
      hdr_lost_inc = 1'b0;
      ftr_lost_inc = 1'b0;
      len_err_inc  = 1'b0;
      case (state)
         IDLE, DISCARD: begin
            if (accept) begin
               if (is_hdr) begin
                  dout_nx      = DIN;
                  ovalid_nx    = 1'b1;
                  frame_len_nx = DIN[11:0];
                  word_cnt_nx  = 12'd0;
                  state_nx     = FRAME;
               end else if (is_ftr) begin
                  hdr_lost_inc = 1'b1;
                  state_nx     = IDLE;
               end else begin
                  state_nx = DISCARD;
               end
            end
         end
         FRAME: begin
            if (hdr_break) begin
               ftr_lost_inc = 1'b1;
               // With a free output slot the footer is closed at once, so the stall lasts one cycle.
               if (out_free) begin
                  dout_nx   = SYNTH_FTR;
                  ovalid_nx = 1'b1;
                  state_nx  = IDLE;
               end else begin
                  state_nx = CLOSE;
               end
            end else if (accept) begin
               dout_nx   = DIN;
               ovalid_nx = 1'b1;
               if (is_ftr) begin
                  len_err_inc = (word_cnt != frame_len);
                  state_nx    = IDLE;
               end else begin
                  word_cnt_nx = word_cnt + 12'd1;
                  if (word_cnt_nx == MAX_LEN) begin
                     ftr_lost_inc = 1'b1;
                     state_nx     = CLOSE;
                  end
               end
            end
         end
         CLOSE: begin
            if (out_free) begin
               dout_nx   = SYNTH_FTR;
               ovalid_nx = 1'b1;
               state_nx  = IDLE;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RESETN) begin
      if (!RESETN) begin
         state        <= IDLE;
         frame_len    <= 12'd0;
         word_cnt     <= 12'd0;
         DOUT         <= '0;
         oVALID       <= 1'b0;
         started      <= 1'b0;
         HDR_LOST_CNT <= '0;
         FTR_LOST_CNT <= '0;
         LEN_ERR_CNT  <= '0;
      end else begin
         state     <= state_nx;
         frame_len <= frame_len_nx;
         word_cnt  <= word_cnt_nx;
         DOUT      <= dout_nx;
         oVALID    <= ovalid_nx;
         started   <= 1'b1;
         if (hdr_lost_inc && (HDR_LOST_CNT != CNT_MAX)) HDR_LOST_CNT <= HDR_LOST_CNT + 1'b1;
         if (ftr_lost_inc && (FTR_LOST_CNT != CNT_MAX)) FTR_LOST_CNT <= FTR_LOST_CNT + 1'b1;
         if (len_err_inc && (LEN_ERR_CNT != CNT_MAX))   LEN_ERR_CNT  <= LEN_ERR_CNT + 1'b1;
      end
   end

endmodule
`default_nettype wire
